// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed common-anode 7-segment driver with hex decode, per-frame snapshot and 16-level PWM.
// Optional LEADING_ZERO_BLANK_EN suppresses leading zero digits at snapshot time.
module seven_seg_scanner #(
    parameter int NUM_DIGITS       = 8,
    parameter int SYSTEM_FREQUENCY = 100000000,
    parameter int SCAN_FREQUENCY   = 1000
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   digit_enable_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic [3:0]              brightness_i,
    output logic [NUM_DIGITS-1:0]   anode_o,
    output logic [6:0]              cathode_o,
    output logic                    dp_o
);
    localparam int TICKS_PER_DIGIT = SYSTEM_FREQUENCY / (SCAN_FREQUENCY * NUM_DIGITS);
    localparam int SLOT_TICKS      = TICKS_PER_DIGIT / 16;
    localparam int TW              = SLOT_TICKS > 1 ? $clog2(SLOT_TICKS) : 1;
    localparam int DW              = $clog2(NUM_DIGITS);
    localparam logic [6:0] SEG_LUT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    if (SLOT_TICKS < 1 || NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_params
        $error("seven_seg_scanner: SLOT_TICKS must be >= 1 and NUM_DIGITS within 2..16");
    end

    logic [TW-1:0]           r_tick;
    logic [3:0]              r_slot;
    logic [DW-1:0]           r_digit;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_blank;
    logic [3:0]              r_bright;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_cathode;
    logic                    r_dpo;

    logic                    w_tick_last;
    logic                    w_slot_last;
    logic                    w_digit_last;
    logic                    w_frame_end;
    logic                    w_guard;
    logic                    w_on;
    logic                    w_blank_dig;
    logic [3:0]              w_nib;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [NUM_DIGITS-1:0]   w_blank;

    assign w_tick_last  = r_tick == TW'(SLOT_TICKS - 1);
    assign w_slot_last  = r_slot == 4'hF;
    assign w_digit_last = r_digit == DW'(NUM_DIGITS - 1);
    assign w_frame_end  = w_tick_last && w_slot_last && w_digit_last;
    assign w_guard      = r_slot == 4'd0 && r_tick == '0;
    assign w_on         = !w_guard && r_slot < r_bright && r_en[r_digit];
    assign w_blank_dig  = r_blank[r_digit];
    assign w_nib        = r_digits[{r_digit, 2'b00} +: 4];
    assign w_sel        = ~(NUM_DIGITS'(1) << r_digit);

`ifdef LEADING_ZERO_BLANK_EN
    // Walk from the top digit down; disabled digits are transparent, the first enabled nonzero digit stops blanking.
    always_comb begin
        logic stop;
        stop    = 1'b0;
        w_blank = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            w_blank[k] = !stop && digit_enable_i[k] && digits_i[4*k +: 4] == 4'h0;
            stop       = stop || (digit_enable_i[k] && digits_i[4*k +: 4] != 4'h0);
        end
    end
`else
    assign w_blank = '0;
`endif

    // Snapshot loads on the edge entering digit 0 / slot 0 / tick 0, so the first frame after reset is dark.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_tick    <= '0;
            r_slot    <= '0;
            r_digit   <= '0;
            r_digits  <= '0;
            r_en      <= '0;
            r_dp      <= '0;
            r_blank   <= '0;
            r_bright  <= '0;
            r_anode   <= '1;
            r_cathode <= 7'h7F;
            r_dpo     <= 1'b1;
        end else begin
            r_tick    <= w_tick_last ? '0 : r_tick + 1'b1;
            r_slot    <= w_tick_last ? r_slot + 4'd1 : r_slot;
            r_digit   <= (w_tick_last && w_slot_last) ? (w_digit_last ? '0 : r_digit + 1'b1) : r_digit;
            r_digits  <= w_frame_end ? digits_i : r_digits;
            r_en      <= w_frame_end ? digit_enable_i : r_en;
            r_dp      <= w_frame_end ? dp_i : r_dp;
            r_blank   <= w_frame_end ? w_blank : r_blank;
            r_bright  <= w_frame_end ? brightness_i : r_bright;
            r_anode   <= (w_on && !(w_blank_dig && !r_dp[r_digit])) ? w_sel : '1;
            r_cathode <= (w_on && !w_blank_dig) ? SEG_LUT[w_nib] : 7'h7F;
            r_dpo     <= w_on ? ~r_dp[r_digit] : 1'b1;
        end
    end

    assign anode_o   = r_anode;
    assign cathode_o = r_cathode;
    assign dp_o      = r_dpo;
endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed checks of scan timing, PWM, snapshot, enable/dp and async reset (4 digits, 256-cycle frame).
module tb_seven_seg_scanner;
    logic        clk = 1'b0;
    logic        reset_i;
    logic [15:0] digits_i;
    logic [3:0]  digit_enable_i;
    logic [3:0]  dp_i;
    logic [3:0]  brightness_i;
    logic [3:0]  anode_o;
    logic [6:0]  cathode_o;
    logic        dp_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] s_an [256];
    logic [6:0] s_ca [256];
    logic       s_dp [256];

    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seven_seg_scanner #(
        .NUM_DIGITS(4),
        .SYSTEM_FREQUENCY(64000),
        .SCAN_FREQUENCY(250)
    ) dut (
        .clock_i(clk),
        .reset_i(reset_i),
        .digits_i(digits_i),
        .digit_enable_i(digit_enable_i),
        .dp_i(dp_i),
        .brightness_i(brightness_i),
        .anode_o(anode_o),
        .cathode_o(cathode_o),
        .dp_o(dp_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Records one frame of outputs; optionally changes digits_i after cycle chg_at.
    task automatic run_frame(input int chg_at, input logic [15:0] chg_val);
        for (int k = 0; k < 256; k++) begin
            @(posedge clk);
            #1;
            s_an[k] = anode_o;
            s_ca[k] = cathode_o;
            s_dp[k] = dp_o;
            if (k == chg_at) digits_i = chg_val;
        end
    endtask

    function automatic int cnt_an(input logic [3:0] v);
        int n = 0;
        for (int k = 0; k < 256; k++) if (s_an[k] == v) n++;
        return n;
    endfunction

    task automatic check_model(input string tag, input logic [15:0] d, input logic [3:0] e,
                               input logic [3:0] p, input logic [3:0] b);
        int errs = 0;
        int multi = 0;
        for (int k = 0; k < 256; k++) begin
            int dg = k / 64;
            int c = k % 64;
            logic on;
            logic [3:0] ea;
            logic [6:0] ec;
            logic ed;
            on = c != 0 && (c / 4) < int'(b) && e[dg];
            ea = on ? ~(4'b0001 << dg) : 4'hF;
            ec = on ? SEG[d[4*dg +: 4]] : 7'h7F;
            ed = on ? ~p[dg] : 1'b1;
            if (s_an[k] !== ea || s_ca[k] !== ec || s_dp[k] !== ed) errs++;
            if ($countones(~s_an[k]) > 1) multi++;
        end
        chk({tag, "_cycles"}, errs, 0);
        chk({tag, "_onehot"}, multi, 0);
    endtask

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] e, input logic [3:0] p, input logic [3:0] b);
        digits_i       = d;
        digit_enable_i = e;
        dp_i           = p;
        brightness_i   = b;
    endtask

    initial begin
        int dp_bad;
        int dp_low;
        int lows;
        reset_i = 1'b1;
        set_inputs(16'h3A7F, 4'hF, 4'h0, 4'd15);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_anode", anode_o, 4'hF);
        chk("reset_cathode", cathode_o, 7'h7F);
        chk("reset_dp", dp_o, 1'b1);
        reset_i = 1'b0;
        run_frame(-1, 16'h0);
        chk("first_frame_dark", 256 - cnt_an(4'hF), 0);

        run_frame(-1, 16'h0);
        check_model("full_scan", 16'h3A7F, 4'hF, 4'h0, 4'd15);
        chk("scan_guard0", s_an[0], 4'hF);
        chk("scan_d0_an", s_an[1], 4'b1110);
        chk("scan_d0_seg", s_ca[1], 7'b0001110);
        chk("scan_d0_last_on", s_an[59], 4'b1110);
        chk("scan_d0_dark", s_an[60], 4'hF);
        chk("scan_guard1", s_an[64], 4'hF);
        chk("scan_d0_count", cnt_an(4'b1110), 59);
        chk("scan_d1_an", s_an[65], 4'b1101);
        chk("scan_d1_seg", s_ca[65], 7'b1111000);
        chk("scan_d2_seg", s_ca[129], 7'b0001000);
        chk("scan_d3_an", s_an[193], 4'b0111);
        chk("scan_d3_seg", s_ca[193], 7'b0110000);

        brightness_i = 4'd4;
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        check_model("bright4", 16'h3A7F, 4'hF, 4'h0, 4'd4);
        chk("bright4_d0_count", cnt_an(4'b1110), 15);
        chk("bright4_d3_count", cnt_an(4'b0111), 15);

        brightness_i = 4'd0;
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        chk("bright0_dark", 256 - cnt_an(4'hF), 0);

        set_inputs(16'h3A7F, 4'b0101, 4'b0100, 4'd15);
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        check_model("en_dp", 16'h3A7F, 4'b0101, 4'b0100, 4'd15);
        chk("en_d1_never", cnt_an(4'b1101), 0);
        chk("en_d3_never", cnt_an(4'b0111), 0);
        dp_bad = 0;
        dp_low = 0;
        for (int k = 0; k < 256; k++) begin
            if (s_dp[k] == 1'b0) dp_low++;
            if (s_dp[k] == 1'b0 && s_an[k] != 4'b1011) dp_bad++;
        end
        chk("dp_low_count", dp_low, 59);
        chk("dp_only_d2", dp_bad, 0);

        set_inputs(16'h1111, 4'hF, 4'h0, 4'd15);
        run_frame(-1, 16'h0);
        run_frame(100, 16'h2222);
        check_model("tear_old", 16'h1111, 4'hF, 4'h0, 4'd15);
        chk("tear_d3_seg", s_ca[193], 7'b1111001);
        run_frame(-1, 16'h0);
        check_model("tear_new", 16'h2222, 4'hF, 4'h0, 4'd15);
        chk("tear_new_d0_seg", s_ca[1], 7'b0100100);

`ifdef LEADING_ZERO_BLANK_EN
        set_inputs(16'h0050, 4'hF, 4'h0, 4'd15);
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        chk("lzb_d3_dark", cnt_an(4'b0111), 0);
        chk("lzb_d2_dark", cnt_an(4'b1011), 0);
        chk("lzb_d1_seg", s_ca[65], 7'b0010010);
        chk("lzb_d0_seg", s_ca[1], 7'b1000000);
        digits_i = 16'h0000;
        run_frame(-1, 16'h0);
        run_frame(-1, 16'h0);
        chk("lzb_zero_d0", cnt_an(4'b1110), 59);
        chk("lzb_zero_dark", 256 - cnt_an(4'hF) - cnt_an(4'b1110), 0);
`endif

        set_inputs(16'h3A7F, 4'hF, 4'h1, 4'd15);
        for (int i = 0; i < 300 && anode_o == 4'hF; i++) begin
            @(posedge clk);
            #1;
        end
        chk("midreset_found_on", anode_o != 4'hF, 1'b1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("midreset_anode", anode_o, 4'hF);
        chk("midreset_cathode", cathode_o, 7'h7F);
        chk("midreset_dp", dp_o, 1'b1);
        @(posedge clk);
        #1;
        reset_i = 1'b0;
        run_frame(-1, 16'h0);
        lows = 256 - cnt_an(4'hF);
        chk("after_reset_dark", lows, 0);
        run_frame(-1, 16'h0);
        check_model("after_reset_scan", 16'h3A7F, 4'hF, 4'h1, 4'd15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
Parametrised multiplexed 7-segment display driver, successor to the two-digit play/record clip display. Scans NUM_DIGITS common-anode digits with full hex decode, per-digit enable and decimal point, and 16-level PWM brightness. A one-cycle anode guard at each digit change prevents ghosting. Inputs are snapshotted per frame so the display never tears. Sits between the control/clip logic and the board display pins.

Parameters:
NUM_DIGITS, 8, number of scanned digits (2..16)
SYSTEM_FREQUENCY, 100000000, clock_i frequency in Hz
SCAN_FREQUENCY, 1000, full-frame refresh rate in Hz (all digits once per frame)

Ports:
clock_i  input  1  system clock
reset_i  input  1  asynchronous active-high reset
digits_i  input  4*NUM_DIGITS  hex nibble per digit; digit k = digits_i[4k+3:4k], digit 0 = rightmost
digit_enable_i  input  NUM_DIGITS  1 = digit k shown, 0 = digit k blanked
dp_i  input  NUM_DIGITS  1 = decimal point lit on digit k
brightness_i  input  4  on-slots per digit dwell (0 = dark, 15 = 15/16 duty)
anode_o  output  NUM_DIGITS  active-low digit select
cathode_o  output  7  active-low segments {g,f,e,d,c,b,a}
dp_o  output  1  active-low decimal point

Behaviour:
- Derived values: TICKS_PER_DIGIT = SYSTEM_FREQUENCY/(SCAN_FREQUENCY*NUM_DIGITS). SLOT_TICKS = TICKS_PER_DIGIT/16. Integer truncation.
- Elaboration error if SLOT_TICKS < 1 or NUM_DIGITS is outside 2..16.
- Dwell is exactly 16*SLOT_TICKS cycles. Frame is NUM_DIGITS dwells.
- Counters: tick (0..SLOT_TICKS-1), slot (0..15), digit (0..NUM_DIGITS-1). All wrap. Digit wraps NUM_DIGITS-1 -> 0.
- Reset (asynchronous, active-high):
  - anode_o = all 1s, cathode_o = 7'b1111111, dp_o = 1.
  - All counters 0. Snapshot registers cleared (all digits disabled).
- First frame after reset release is dark, because the snapshot is empty.
- Snapshot: at the cycle where digit=0, slot=0, tick=0, latch digits_i, digit_enable_i, dp_i and brightness_i. Mid-frame input changes take effect at the next frame start.
- Phase per cycle:
  - GUARD: slot=0 and tick=0. All anodes high.
  - ON: not GUARD, slot < snapshot brightness, and the current digit is enabled.
  - OFF: every other cycle.
- Outputs, registered one cycle after the counter state:
  - ON: anode_o has only bit[digit] = 0. cathode_o = hex decode of the nibble. dp_o = ~dp.
  - GUARD/OFF: anode_o all 1s, cathode_o all 1s, dp_o 1.
- Hex decode (gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- At most one anode_o bit is low in any cycle.
- Reset asserted mid-frame forces all outputs inactive immediately, without waiting for a clock edge.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: at snapshot time, enabled digits from NUM_DIGITS-1 downward whose nibble is 0 are blanked. Blanking stops at the first enabled nonzero nibble.
  - Digit 0 is never blanked.
  - A disabled digit does not stop the scan.
  - A blanked digit still shows its dp if dp_i is set: anode low, cathode all 1s, dp_o 0.
- Undefined: nibbles are displayed as decoded, with no zero suppression.

Test Plan:
Bench parameters: NUM_DIGITS=4, SYSTEM_FREQUENCY=64000, SCAN_FREQUENCY=250. This gives TICKS_PER_DIGIT=64, SLOT_TICKS=4, frame=256 cycles.
- Reset check: assert reset_i asynchronously mid-ON -> anode_o=4'b1111, cathode_o=7'b1111111, dp_o=1 before the next edge. The first frame after release is dark.
- Full scan: digits_i=16'h3A7F, all enabled, brightness_i=15 -> digit0 shows 0001110 for 59 cycles then dark for 4. Digits 1,2,3 then show 1111000, 0001000, 0110000. Anodes step 1110, 1101, 1011, 0111. Each dwell has 1 guard cycle. Never more than one anode low.
- Brightness: brightness_i=4 -> anode low for 15 cycles per 64-cycle dwell. brightness_i=0 -> anode_o stays 4'b1111 for a whole frame.
- Tearing: change digits_i from 16'h1111 to 16'h2222 at cycle 100 of a frame -> the remaining digits still show 1. All digits show 2 from the next frame start.
- Enable/dp: digit_enable_i=4'b0101, dp_i=4'b0100 -> digits 1 and 3 anodes never low. dp_o=0 only while anode_o=4'b1011.
- LEADING_ZERO_BLANK_EN defined: digits_i=16'h0050, all enabled, dp_i=0 -> digit3 dark, digit2 dark, digit1 shows 0010010, digit0 shows 1000000. digits_i=16'h0000 -> only digit0 lit.
